// File: rtl/coproc_pkg.sv
// coproc_pkg: shared types and constants for the coprocessor arbiter
package coproc_pkg;
    localparam int INSTR_W  = 32;
    localparam int RESULT_W = 16;
    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_START,
        WAIT_END
    } state_t;
    localparam logic OWNER_HPS = 1'b0;
    localparam logic OWNER_IPU = 1'b1;
    localparam logic [3:0] OP_READ      = 4'b0001;
    localparam logic [3:0] OP_WRITE     = 4'b0010;
    localparam logic [3:0] OP_CONV      = 4'b0101;
    localparam logic [3:0] OP_CONV_TRSP = 4'b0110;
    localparam logic [3:0] OP_CONV_ROB  = 4'b0111;
    localparam logic [3:0] OP_B2G       = 4'b1000;
endpackage

// File: rtl/coproc_watchdog.sv
// coproc_watchdog: saturating cycle counter that flags expiry after LIMIT enabled cycles
module coproc_watchdog
    import coproc_pkg::*;
#(
    parameter int LIMIT = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);
    localparam int W = $clog2(LIMIT + 1);
    logic [W-1:0] r_count;
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_count <= '0;
        else if (i_clear)
            r_count <= '0;
        else if (i_enable && r_count != W'(LIMIT))
            r_count <= r_count + W'(1);
    end
    assign o_expired = (r_count == W'(LIMIT));
endmodule

// File: rtl/coproc_arbiter.sv
// coproc_arbiter: round-robin sharing of the convolution coprocessor between HPS and IPU
module coproc_arbiter
    import coproc_pkg::*;
#(
    parameter int TIMEOUT     = 4096,
    parameter int START_LIMIT = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [INSTR_W-1:0]  hps_instruction,
    input  logic                hps_valid,
    output logic                hps_ready,
    output logic                hps_done,
    output logic [RESULT_W-1:0] hps_result,
    input  logic [INSTR_W-1:0]  ipu_instruction,
    input  logic                ipu_valid,
    output logic                ipu_ready,
    output logic                ipu_done,
    output logic [INSTR_W-1:0]  cop_instruction,
    output logic                cop_activate,
    output logic                cop_ipu_request,
    input  logic                cop_wait,
    input  logic [RESULT_W-1:0] cop_output_reg,
    output logic                owner,
    output logic                busy,
    output logic                err_timeout,
    output logic                err_no_start
);
    state_t r_state, w_next;
    logic r_owner, r_last, r_ipu_req, r_err_timeout, r_err_no_start;
    logic [INSTR_W-1:0] r_instr;
    logic [RESULT_W-1:0] r_result;
    logic w_sel, w_grant, w_start_exp, w_to_exp, w_no_start, w_end, w_done;

    // Grant is gated by reset so no ready pulse leaks out while reset is held
    assign w_sel      = (hps_valid && ipu_valid) ? ~r_last : ipu_valid;
    assign w_grant    = !reset && r_state == IDLE && !cop_wait && (hps_valid || ipu_valid);
    assign w_no_start = r_state == WAIT_START && !cop_wait && w_start_exp;
    assign w_end      = r_state == WAIT_END && !cop_wait;
    assign w_done     = w_no_start || w_end;

    coproc_watchdog #(.LIMIT(START_LIMIT)) u_start_wd (
        .clk       (clk),
        .reset     (reset),
        .i_clear   (r_state == IDLE),
        .i_enable  (r_state == ISSUE || r_state == WAIT_START),
        .o_expired (w_start_exp)
    );

    coproc_watchdog #(.LIMIT(TIMEOUT)) u_timeout_wd (
        .clk       (clk),
        .reset     (reset),
        .i_clear   (r_state == IDLE),
        .i_enable  (r_state != IDLE && cop_wait),
        .o_expired (w_to_exp)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:       w_next = w_grant ? ISSUE : IDLE;
            ISSUE:      w_next = WAIT_START;
            WAIT_START: w_next = cop_wait ? WAIT_END : (w_start_exp ? IDLE : WAIT_START);
            WAIT_END:   w_next = cop_wait ? WAIT_END : IDLE;
            default:    w_next = IDLE;
        endcase
    end

    always_comb begin
        hps_ready    = w_grant && w_sel == OWNER_HPS;
        ipu_ready    = w_grant && w_sel == OWNER_IPU;
        hps_done     = w_done && r_owner == OWNER_HPS;
        ipu_done     = w_done && r_owner == OWNER_IPU;
        cop_activate = r_state == ISSUE;
        busy         = r_state != IDLE;
    end

    // Last-served starts at IPU so the first tie goes to HPS
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_instr        <= '0;
            r_owner        <= OWNER_HPS;
            r_last         <= OWNER_IPU;
            r_ipu_req      <= 1'b0;
            r_result       <= '0;
            r_err_timeout  <= 1'b0;
            r_err_no_start <= 1'b0;
        end else begin
            if (w_grant) begin
                r_instr <= w_sel ? ipu_instruction : hps_instruction;
                r_owner <= w_sel;
                r_last  <= w_sel;
            end
            r_ipu_req <= w_grant ? w_sel : (w_next == IDLE ? 1'b0 : r_ipu_req);
            if (w_end && r_owner == OWNER_HPS)
                r_result <= cop_output_reg;
            if (w_no_start)
                r_err_no_start <= 1'b1;
            if (w_to_exp)
                r_err_timeout <= 1'b1;
        end
    end

    assign owner           = r_owner;
    assign cop_instruction = r_instr;
    assign cop_ipu_request = r_ipu_req;
    assign hps_result      = r_result;
    assign err_timeout     = r_err_timeout;
    assign err_no_start    = r_err_no_start;
endmodule

// File: tb/tb_coproc_arbiter.sv
// tb_coproc_arbiter: table-driven and scoreboarded bench with a behavioural coprocessor
module tb_coproc_arbiter;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] hps_instruction = '0, ipu_instruction = '0;
    logic        hps_valid = 1'b0, ipu_valid = 1'b0;
    logic        hps_ready, hps_done, ipu_ready, ipu_done;
    logic [15:0] hps_result;
    logic [31:0] cop_instruction;
    logic        cop_activate, cop_ipu_request, owner, busy, err_timeout, err_no_start;
    logic        cop_wait = 1'b0;
    logic [15:0] cop_output_reg = '0;

    coproc_arbiter #(.TIMEOUT(4096), .START_LIMIT(2)) dut (
        .clk             (clk),
        .reset           (reset),
        .hps_instruction (hps_instruction),
        .hps_valid       (hps_valid),
        .hps_ready       (hps_ready),
        .hps_done        (hps_done),
        .hps_result      (hps_result),
        .ipu_instruction (ipu_instruction),
        .ipu_valid       (ipu_valid),
        .ipu_ready       (ipu_ready),
        .ipu_done        (ipu_done),
        .cop_instruction (cop_instruction),
        .cop_activate    (cop_activate),
        .cop_ipu_request (cop_ipu_request),
        .cop_wait        (cop_wait),
        .cop_output_reg  (cop_output_reg),
        .owner           (owner),
        .busy            (busy),
        .err_timeout     (err_timeout),
        .err_no_start    (err_no_start)
    );

    always #5 clk = ~clk;

    // Coprocessor: memory ops hold wait one cycle, others cfg_hold cycles; result = instr[31:16] ^ BEEF
    int   hold_cnt = 0;
    int   cfg_hold = 1;
    logic no_start_mode = 1'b0;
    always @(posedge clk) begin
        if (cop_activate && !no_start_mode) begin
            cop_wait       <= 1'b1;
            hold_cnt       <= (cop_instruction[3:0] == 4'b0001 || cop_instruction[3:0] == 4'b0010) ? 1 : cfg_hold;
            cop_output_reg <= cop_instruction[31:16] ^ 16'hBEEF;
        end else if (cop_wait) begin
            hold_cnt <= hold_cnt - 1;
            if (hold_cnt <= 1)
                cop_wait <= 1'b0;
        end
    end

    typedef struct {
        logic        owner;
        logic [31:0] instr;
        logic [15:0] res;
    } exp_t;

    typedef struct {
        logic        hv;
        logic        iv;
        logic [31:0] hi;
        logic [31:0] ii;
        logic        first_ipu;
        int          cycles;
    } vec_t;

    exp_t        exp_q[$];
    vec_t        tbl[8];
    int          checks = 0;
    int          errors = 0;
    logic        res_pending = 1'b0;
    logic [15:0] res_exp = '0;
    int          lat, used;
    logic        got;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, expv, $time);
        end
    endtask

    function automatic logic [63:0] all_out();
        return {6'b0, hps_ready, hps_done, hps_result, ipu_ready, ipu_done, cop_instruction,
                cop_activate, cop_ipu_request, owner, busy, err_timeout, err_no_start};
    endfunction

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    // Sample one cycle at the falling edge and run the scoreboard monitor
    task automatic tick();
        exp_t e;
        @(negedge clk);
        if (res_pending) begin
            chk("hps_result", hps_result, res_exp);
            res_pending = 1'b0;
        end
        if (busy && exp_q.size() != 0) begin
            chk("owner", owner, exp_q[0].owner);
            chk("ipu_request", cop_ipu_request, exp_q[0].owner);
        end else if (!busy)
            chk("ipu_request_idle", cop_ipu_request, 0);
        if (cop_activate) begin
            if (exp_q.size() == 0)
                chk("activate_unexpected", cop_activate, 0);
            else
                chk("cop_instruction", cop_instruction, exp_q[0].instr);
        end
        if (hps_done || ipu_done) begin
            if (exp_q.size() == 0)
                chk("done_unexpected", hps_done | ipu_done, 0);
            else begin
                e = exp_q.pop_front();
                chk("hps_done", hps_done, !e.owner);
                chk("ipu_done", ipu_done, e.owner);
                if (!e.owner) begin
                    res_pending = 1'b1;
                    res_exp = e.res;
                end
            end
        end
    endtask

    task automatic push(input logic ipu, input logic [31:0] instr, input logic [15:0] res);
        exp_t e;
        e.owner = ipu;
        e.instr = instr;
        e.res   = res;
        exp_q.push_back(e);
    endtask

    task automatic run_ops(input int max, output int n_used);
        logic dh, di;
        n_used = -1;
        for (int n = 0; n < max; n++) begin
            tick();
            if (exp_q.size() == 0 && !res_pending && !hps_valid && !ipu_valid) begin
                n_used = n;
                return;
            end
            dh = hps_ready;
            di = ipu_ready;
            next();
            if (dh) hps_valid = 1'b0;
            if (di) ipu_valid = 1'b0;
        end
    endtask

    // Single op; returns cycles from the ready pulse (G) to the done pulse
    task automatic timed_op(input logic ipu, input logic [31:0] instr, input logic [15:0] res,
                            input int max, output int l);
        push(ipu, instr, res);
        next();
        if (ipu) begin
            ipu_instruction = instr;
            ipu_valid = 1'b1;
        end else begin
            hps_instruction = instr;
            hps_valid = 1'b1;
        end
        tick();
        chk("grant_ready", ipu ? ipu_ready : hps_ready, 1);
        next();
        hps_valid = 1'b0;
        ipu_valid = 1'b0;
        l = -1;
        for (int n = 1; n <= max; n++) begin
            tick();
            if (n == 1) chk("activate_g1", cop_activate, 1);
            if (n == 2) chk("activate_g2", cop_activate, 0);
            if (n == 4090) chk("err_timeout_early", err_timeout, 0);
            if (n == 4110) chk("err_timeout_late", err_timeout, 1);
            if (hps_done || ipu_done) begin
                l = n;
                break;
            end
            next();
        end
    endtask

    task automatic pulse_reset();
        next();
        reset = 1'b1;
        tick();
        chk("reset_outputs", all_out(), 0);
        next();
        reset = 1'b0;
    endtask

    initial begin
        tbl[0] = '{1'b1, 1'b1, 32'h1111_0001, 32'h2222_0002, 1'b0, 7};
        tbl[1] = '{1'b1, 1'b1, 32'h3333_0002, 32'h4444_0001, 1'b0, 7};
        tbl[2] = '{1'b1, 1'b1, 32'h5555_0001, 32'h6666_0001, 1'b0, 7};
        tbl[3] = '{1'b1, 1'b1, 32'h7777_0002, 32'h8888_0002, 1'b0, 7};
        tbl[4] = '{1'b1, 1'b0, 32'h9999_0001, 32'h0000_0000, 1'b0, 4};
        tbl[5] = '{1'b1, 1'b1, 32'hAAAA_0002, 32'hBBBB_0001, 1'b1, 8};
        tbl[6] = '{1'b0, 1'b1, 32'h0000_0000, 32'hCCCC_0001, 1'b0, 3};
        tbl[7] = '{1'b1, 1'b1, 32'hDDDD_0002, 32'hEEEE_0001, 1'b0, 7};

        tick();
        chk("reset_outputs", all_out(), 0);
        next();
        reset = 1'b0;

        // Single HPS read
        timed_op(1'b0, 32'h0000_0001, 16'hBEEF, 20, lat);
        chk("read_latency", lat, 3);
        next();
        tick();
        chk("read_result", hps_result, 16'hBEEF);

        // Round-robin table, starting from reset so HPS wins the first tie
        pulse_reset();
        foreach (tbl[i]) begin
            if (tbl[i].hv && tbl[i].iv) begin
                if (tbl[i].first_ipu) begin
                    push(1'b1, tbl[i].ii, 16'h0);
                    push(1'b0, tbl[i].hi, tbl[i].hi[31:16] ^ 16'hBEEF);
                end else begin
                    push(1'b0, tbl[i].hi, tbl[i].hi[31:16] ^ 16'hBEEF);
                    push(1'b1, tbl[i].ii, 16'h0);
                end
            end else if (tbl[i].hv)
                push(1'b0, tbl[i].hi, tbl[i].hi[31:16] ^ 16'hBEEF);
            else
                push(1'b1, tbl[i].ii, 16'h0);
            next();
            hps_instruction = tbl[i].hi;
            ipu_instruction = tbl[i].ii;
            hps_valid = tbl[i].hv;
            ipu_valid = tbl[i].iv;
            run_ops(40, used);
            chk($sformatf("row%0d_cycles", i), used, tbl[i].cycles);
        end
        chk("errs_after_table", {err_timeout, err_no_start}, 0);

        // IPU CONV with wait held 30 cycles
        cfg_hold = 30;
        timed_op(1'b1, 32'hC0DE_0005, 16'h0, 100, lat);
        chk("conv_latency", lat, 32);
        next();
        tick();
        chk("conv_errs", {err_timeout, err_no_start}, 0);

        // Reset while in WAIT_END with the coprocessor still busy
        cfg_hold = 20;
        push(1'b1, 32'h1234_0005, 16'h0);
        next();
        ipu_instruction = 32'h1234_0005;
        ipu_valid = 1'b1;
        tick();
        chk("midop_grant", ipu_ready, 1);
        next();
        ipu_valid = 1'b0;
        repeat (5) begin
            tick();
            next();
        end
        reset = 1'b1;
        exp_q.delete();
        push(1'b0, 32'h5678_0001, 16'h5678 ^ 16'hBEEF);
        hps_instruction = 32'h5678_0001;
        hps_valid = 1'b1;
        tick();
        chk("midop_reset_outputs", all_out(), 0);
        next();
        reset = 1'b0;
        got = 1'b0;
        for (int n = 0; n < 60; n++) begin
            tick();
            if (!cop_wait) begin
                chk("grant_after_wait", hps_ready, 1);
                got = 1'b1;
                break;
            end
            chk("hold_during_wait", {hps_ready, hps_done, ipu_done}, 0);
            next();
        end
        chk("wait_fall_seen", got, 1);
        next();
        hps_valid = 1'b0;
        run_ops(20, used);
        chk("midop_follow_cycles", used, 3);

        // Wait held past TIMEOUT
        cfg_hold = 5000;
        timed_op(1'b1, 32'h0F0F_0005, 16'h0, 6000, lat);
        chk("timeout_latency", lat, 5002);
        chk("timeout_flag", {err_timeout, err_no_start}, 2'b10);
        next();
        tick();
        pulse_reset();

        // Coprocessor never raises wait
        no_start_mode = 1'b1;
        timed_op(1'b0, 32'h0000_0001, 16'h0, 10, lat);
        chk("nostart_latency", lat, 3);
        next();
        tick();
        chk("nostart_flags", {err_timeout, err_no_start, busy}, 3'b010);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/coproc_arbiter.md
# coproc_arbiter

Shares the single convolution coprocessor between two instruction requesters: the HPS bridge and the image processing unit (IPU). It sits directly in front of the coprocessor's instruction port. It grants access round-robin and issues one instruction at a time using the coprocessor's `activate_instruction`/`wait_signal` protocol. It holds `ipu_request` for the whole IPU operation, returns `output_reg` to the owning requester, and flags coprocessors that are hung or unresponsive.

## Interface
Parameters:
- `TIMEOUT`, 4096: max cycles `cop_wait` may stay high before `err_timeout` sets.
- `START_LIMIT`, 2: max cycles after issue for `cop_wait` to rise before `err_no_start` sets.

Ports:
- `clk`, in, 1: the only clock.
- `reset`, in, 1: asynchronous, active-high.
- `hps_instruction`, in, 32: HPS instruction word.
- `hps_valid`, in, 1: HPS request pending.
- `hps_ready`, out, 1: 1-cycle accept pulse.
- `hps_done`, out, 1: 1-cycle completion pulse.
- `hps_result`, out, 16: `cop_output_reg` captured at HPS completion.
- `ipu_instruction`, in, 32: IPU instruction word.
- `ipu_valid`, in, 1: IPU request pending.
- `ipu_ready`, out, 1: 1-cycle accept pulse.
- `ipu_done`, out, 1: 1-cycle completion pulse.
- `cop_instruction`, out, 32: to coprocessor `instruction`.
- `cop_activate`, out, 1: to `activate_instruction`.
- `cop_ipu_request`, out, 1: to `ipu_request`.
- `cop_wait`, in, 1: from `wait_signal`.
- `cop_output_reg`, in, 16: from `output_reg`.
- `owner`, out, 1: 0 = HPS, 1 = IPU. Valid while `busy`.
- `busy`, out, 1: an operation is in flight.
- `err_timeout`, out, 1: sticky; cleared only by `reset`.
- `err_no_start`, out, 1: sticky; cleared only by `reset`.

## Operation
States and transitions:
- IDLE: no operation in flight.
  - Arbitration runs only when `cop_wait` = 0.
  - If both valid, grant the requester not served last. Otherwise grant whichever is valid.
  - On grant: pulse that requester's ready, latch its instruction into `cop_instruction`, set `owner`, go to ISSUE.
- ISSUE: `cop_activate` = 1 for exactly this cycle. Go to WAIT_START.
- WAIT_START:
  - If `cop_wait` = 1, go to WAIT_END.
  - If it stays 0 for `START_LIMIT` cycles, set `err_no_start`, pulse the owner's done, go to IDLE.
- WAIT_END:
  - When `cop_wait` = 0, pulse the owner's done and go to IDLE.
  - If owner is HPS, latch `hps_result` <= `cop_output_reg` in the same cycle.
  - The cycle counter saturates. On reaching `TIMEOUT`, set `err_timeout` and keep waiting; never abort.

Rules:
- `cop_ipu_request` = (`owner` == IPU) in ISSUE, WAIT_START and WAIT_END; 0 in IDLE. It is registered and stable for the whole operation.
- `cop_instruction` holds its value until the next grant.
- `busy` = (state != IDLE).
- Requesters hold valid and the instruction stable until their ready pulse. Valid sampled in the cycle of its own ready pulse does not re-request.
- The last-served flag updates on grant.
- Reset value 0 for every output, `hps_result` and `cop_instruction` included. Last-served resets to IPU, so HPS wins the first tie.
- Reset mid-operation: the state machine returns to IDLE. The coprocessor has no reset, so the next grant waits until `cop_wait` = 0. No done pulse is produced for the aborted operation.

## Timing
- Grant to activate: ready pulse at cycle G, `cop_activate` at G+1.
- The coprocessor raises `cop_wait` at G+2.
- Memory ops (READ 4'b0001, WRITE 4'b0010) drop wait at G+3. Done pulses at G+3 and `hps_result` is valid from G+4.
- Back-to-back: the next grant can occur in the cycle after done, provided `cop_wait` = 0.
- Minimum throughput: one memory op per 4 cycles.
- Timeout counter width: `$clog2(TIMEOUT+1)`.

## Structure
- Shared package `coproc_pkg`:
  - state encoding (IDLE, ISSUE, WAIT_START, WAIT_END);
  - owner constants OWNER_HPS = 0, OWNER_IPU = 1;
  - coprocessor opcode constants (READ, WRITE, CONV, CONV_TRSP, CONV_ROB, B2G);
  - instruction width 32 and result width 16.
- One natural sub-module, `coproc_watchdog`: a saturating counter with clear and enable that outputs `expired`. It is instantiated twice, once for `START_LIMIT` and once for `TIMEOUT`.

## Test plan
- **Single HPS read.** `hps_instruction` = 32'h0000_0001, bench coprocessor returns 16'hBEEF. Expect `hps_ready` at G, `cop_activate` at G+1, `hps_done` at G+3, `hps_result` = 16'hBEEF, `cop_ipu_request` = 0 throughout.
- **Simultaneous requests, four ops each.** Grants alternate HPS, IPU, HPS, IPU… (HPS first after reset). `cop_ipu_request` = 1 exactly during the IPU operations.
- **IPU CONV (opcode 4'b0101), wait held 30 cycles.** `cop_ipu_request` stays 1 for all 30 cycles. `ipu_done` pulses one cycle after wait falls. No error flags set.
- **Wait held 5000 cycles with `TIMEOUT` = 4096.** `err_timeout` rises at cycle 4096 of WAIT_END. Done still pulses only when wait falls.
- **Coprocessor never raises wait.** `err_no_start` sets 2 cycles after activate, the owner's done pulses, and the arbiter returns to IDLE.
- **`reset` asserted during WAIT_END with `cop_wait` still high.** All outputs go to 0 and no done pulse is produced. A pending `hps_valid` is not granted until `cop_wait` falls.
